// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles bytes, checks length (and FCS when
// MII_RX_FCS_CHECK_EN is defined) and emits a non-stallable byte stream with end status.
module mii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  phy_rxd,
  input  logic        phy_rx_dv,
  input  logic        phy_rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_error,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

`ifdef MII_RX_FCS_CHECK_EN
  // The last four bytes are the FCS, so they stay behind the emitted data.
  localparam int DEPTH = 5;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [2:0]  DEPTH_F = 3'(DEPTH);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DATA  = 3'd2,
    S_END = 3'd3,
    DROP  = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic [1:0]  pre_cnt;
  logic        half;
  logic [3:0]  low_nib;
  logic [10:0] byte_cnt;
  logic        err_flag;
  logic        frame_bad;
  logic [2:0]  fill;
  logic [7:0]  hold [DEPTH];

  logic [7:0]  byte_in;
  logic [10:0] cnt_inc;
  logic        fcs_bad;
  logic        flush_err;

`ifdef MII_RX_FCS_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd   <= 4'h0;
      rx_dv <= 1'b0;
      rx_er <= 1'b0;
    end else begin
      rxd   <= phy_rxd;
      rx_dv <= phy_rx_dv;
      rx_er <= phy_rx_er;
    end
  end

  always_comb begin
    byte_in = {rxd, low_nib};
    cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
`ifdef MII_RX_FCS_CHECK_EN
    fcs_bad = (crc != 32'hDEBB20E3);
`else
    fcs_bad = 1'b0;
`endif
    // rx_er is included so an error coinciding with the rx_dv fall still counts.
    flush_err = err_flag | rx_er | half | (byte_cnt < MIN_L) | fcs_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pre_cnt   <= 2'd0;
      half      <= 1'b0;
      low_nib   <= 4'h0;
      byte_cnt  <= 11'd0;
      err_flag  <= 1'b0;
      frame_bad <= 1'b0;
      fill      <= 3'd0;
      for (int i = 0; i < DEPTH; i++) hold[i] <= 8'h00;
`ifdef MII_RX_FCS_CHECK_EN
      crc       <= 32'hFFFFFFFF;
`endif
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_error   <= 1'b0;
      frame_cnt <= 16'h0000;
      err_cnt   <= 16'h0000;
    end else begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_dv) begin
            if (rxd == 4'h5) begin
              state   <= PRE;
              pre_cnt <= 2'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rxd == 4'h5) begin
            if (pre_cnt != 2'd3) pre_cnt <= pre_cnt + 2'd1;
          end else if ((rxd == 4'hD) && (pre_cnt >= 2'd2)) begin
            state    <= DATA;
            half     <= 1'b0;
            byte_cnt <= 11'd0;
            err_flag <= 1'b0;
            fill     <= 3'd0;
`ifdef MII_RX_FCS_CHECK_EN
            crc      <= 32'hFFFFFFFF;
`endif
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!rx_dv) begin
            state <= S_END;
            // A frame whose buffer never filled has nothing to emit and no m_last.
            if (fill == DEPTH_F) begin
              m_data    <= hold[0];
              m_valid   <= 1'b1;
              m_last    <= 1'b1;
              m_error   <= flush_err;
              frame_bad <= flush_err;
            end else begin
              frame_bad <= 1'b1;
            end
          end else begin
            if (rx_er) err_flag <= 1'b1;
            if (!half) begin
              low_nib <= rxd;
              half    <= 1'b1;
            end else begin
              half     <= 1'b0;
              byte_cnt <= cnt_inc;
`ifdef MII_RX_FCS_CHECK_EN
              crc      <= crc32_byte(crc, byte_in);
`endif
              if (cnt_inc > MAX_L) begin
                err_flag <= 1'b1;
              end else if (fill == DEPTH_F) begin
                m_data  <= hold[0];
                m_valid <= 1'b1;
                for (int i = 0; i < DEPTH - 1; i++) hold[i] <= hold[i+1];
                hold[DEPTH-1] <= byte_in;
              end else begin
                for (int i = 0; i < DEPTH; i++) begin
                  if (fill == 3'(i)) hold[i] <= byte_in;
                end
                fill <= fill + 3'd1;
              end
            end
          end
        end
        S_END: begin
          state <= IDLE;
          if (frame_bad) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end else begin
            if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
          end
        end
        DROP: begin
          if (!rx_dv) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
